// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor d = a - b, LSB first, one bit per clock.
// A single borrow flop ripples between bits; result and borrow-out are registered.
module serial_sub #(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bo
);
    localparam int            CW   = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  sa, sb, sr;
    logic          borrow;
    logic [CW-1:0] cnt;

    logic          x, y, dbit, borrow_nxt;
    logic [W-1:0]  sr_nxt;

    always_comb begin
        x          = sa[0];
        y          = sb[0];
        dbit       = x ^ y ^ borrow;
        borrow_nxt = (~x & y) | (~(x ^ y) & borrow);
        // diff bit enters at the MSB so after W shifts sr holds the LSB-first result
        sr_nxt     = (sr >> 1) | (W'(dbit) << (W - 1));
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bo     <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        sr     <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    sr     <= sr_nxt;
                    borrow <= borrow_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        d     <= sr_nxt;
                        bo    <= borrow_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: W=8 vector table plus multi-cycle corner sequences,
// and a W=1 instance exercising all four single-bit cases.
module tb_serial_sub;
    logic       ck = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       busy8, done8, bo8;
    logic [7:0] d8;
    logic       busy1, done1, bo1;
    logic [0:0] d1;

    int checks = 0;
    int errors = 0;

    always #5 ck = ~ck;

    serial_sub #(.W(8)) dut8 (
        .ck(ck), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .d(d8), .bo(bo8)
    );

    serial_sub #(.W(1)) dut1 (
        .ck(ck), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .d(d1), .bo(bo1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec8_t;

    typedef struct {
        logic [0:0] a;
        logic [0:0] b;
        logic [0:0] d;
        logic       bo;
    } vec1_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One full W=8 transaction from IDLE, checking latency, busy width, result and done width.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ed,
                       input logic ebo, input string nm);
        int i, nbusy;
        @(negedge ck);
        a8 = ta; b8 = tb_; start8 = 1'b1;
        @(negedge ck);
        start8 = 1'b0; a8 = ~ta; b8 = ~tb_;
        i = 0; nbusy = 0;
        while (!done8 && i < 14) begin
            if (busy8) nbusy++;
            @(negedge ck);
            i++;
        end
        chk({nm, " latency"}, i, 8);
        chk({nm, " busy_cycles"}, nbusy, 8);
        chk({nm, " done"}, done8, 1);
        chk({nm, " busy_at_done"}, busy8, 0);
        chk({nm, " d"}, d8, ed);
        chk({nm, " bo"}, bo8, ebo);
        @(negedge ck);
        chk({nm, " done_width"}, done8, 0);
    endtask

    task automatic op1(input logic [0:0] ta, input logic [0:0] tb_, input logic [0:0] ed,
                       input logic ebo, input string nm);
        @(negedge ck);
        a1 = ta; b1 = tb_; start1 = 1'b1;
        @(negedge ck);
        start1 = 1'b0; a1 = ~ta; b1 = ~tb_;
        chk({nm, " busy"}, busy1, 1);
        @(negedge ck);
        chk({nm, " done"}, done1, 1);
        chk({nm, " d"}, d1, ed);
        chk({nm, " bo"}, bo1, ebo);
        @(negedge ck);
        chk({nm, " done_width"}, done1, 0);
    endtask

    vec8_t tab8[5];
    vec1_t tab1[4];

    initial begin
        int ndone, t, t1, gap;

        tab8[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        tab8[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        tab8[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
        tab8[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        tab8[4] = '{8'h01, 8'hFF, 8'h02, 1'b1};
        tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tab1[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tab1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tab1[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
        a8 = 8'hAA; b8 = 8'h55; a1 = 1'b1; b1 = 1'b0;
        repeat (3) @(negedge ck);
        chk("reset busy8", busy8, 0);
        chk("reset done8", done8, 0);
        chk("reset d8", d8, 0);
        chk("reset bo8", bo8, 0);
        chk("reset busy1", busy1, 0);
        chk("reset d1", d1, 0);
        start8 = 1'b0; start1 = 1'b0;
        rst = 1'b0;
        @(negedge ck);
        chk("idle busy8", busy8, 0);

        for (int k = 0; k < 5; k++)
            op8(tab8[k].a, tab8[k].b, tab8[k].d, tab8[k].bo, $sformatf("vec8[%0d]", k));

        for (int k = 0; k < 4; k++)
            op1(tab1[k].a, tab1[k].b, tab1[k].d, tab1[k].bo, $sformatf("vec1[%0d]", k));

        // start pulses in RUN cycle 3 and in the DONE cycle must be ignored
        @(negedge ck);
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        @(negedge ck);               // after accept edge k
        start8 = 1'b0;
        ndone = 0;
        for (t = 1; t <= 26; t++) begin
            @(negedge ck);           // after edge k+t
            if (done8) begin
                ndone++;
                chk("ign d", d8, 8'h0F);
                chk("ign bo", bo8, 0);
            end
            start8 = 1'b0;
            if (t == 2 || t == 8) begin
                a8 = 8'h33; b8 = 8'h22; start8 = 1'b1;
            end
        end
        chk("ign done_count", ndone, 1);
        chk("ign idle", busy8, 0);

        // reset during RUN cycle 4: abort, no done, outputs cleared
        @(negedge ck);
        a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
        @(negedge ck);
        start8 = 1'b0;
        repeat (3) @(negedge ck);    // after edge k+3
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        chk("abort busy", busy8, 0);
        chk("abort done", done8, 0);
        chk("abort d", d8, 0);
        chk("abort bo", bo8, 0);
        ndone = 0;
        repeat (10) begin
            @(negedge ck);
            if (done8) ndone++;
        end
        chk("abort no_done", ndone, 0);
        op8(8'h09, 8'h03, 8'h06, 1'b0, "after_abort");

        // reset on the completion edge wins
        op8(8'h00, 8'h01, 8'hFF, 1'b1, "pre_coincide");
        @(negedge ck);
        a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
        @(negedge ck);
        start8 = 1'b0;
        repeat (7) @(negedge ck);    // after edge k+7
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        chk("coincide done", done8, 0);
        chk("coincide d", d8, 0);
        chk("coincide bo", bo8, 0);
        chk("coincide busy", busy8, 0);

        // start held high: back-to-back operations every W+2 cycles
        @(negedge ck);
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        @(negedge ck);
        a8 = 8'h03; b8 = 8'h05;
        ndone = 0; t1 = 0; gap = 0;
        for (t = 1; t <= 30 && ndone < 2; t++) begin
            @(negedge ck);
            if (done8) begin
                chk("stream busy_with_done", busy8, 0);
                if (ndone == 0) begin
                    t1 = t;
                    chk("stream d0", d8, 8'h02);
                    chk("stream bo0", bo8, 0);
                end else begin
                    gap = t - t1;
                    chk("stream d1", d8, 8'hFE);
                    chk("stream bo1", bo8, 1);
                end
                ndone++;
            end
        end
        start8 = 1'b0;
        chk("stream count", ndone, 2);
        chk("stream gap", gap, 10);
        repeat (14) @(negedge ck);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
